knight_scan_pwm: RTL
====================

KNIGHT_SCAN_PWM -- requirements
Module: knight_scan_pwm

Interface
REQ-001 Parameter N_LEDS, default 8: number of LED outputs, legal range 1..64.
REQ-002 Parameter PWM_BITS, default 4: brightness resolution; MAX = 2^PWM_BITS-1; legal range 2..8.
REQ-003 Parameter PRESC_W, default 16: width of the PWM prescaler load value.
REQ-004 Port clk_in, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-006 Port enable, input, 1: high = run; low = freeze all state.
REQ-007 Port mode, input, 1: 0 = bounce scan, 1 = wrap scan.
REQ-008 Port pwm_div, input, PRESC_W: PWM tick period minus one, in clk_in cycles.
REQ-009 Port step_div, input, 8: PWM frames per scan step minus one.
REQ-010 Port led, output, N_LEDS: PWM-modulated LED drive, registered.
REQ-011 Port pos, output, max(1,clog2(N_LEDS)): current head position.
REQ-012 Port dir, output, 1: scan direction; 1 = increasing index.
REQ-013 Port step_pulse, output, 1: one-cycle strobe, high in the cycle pos first shows a new value.

Function
REQ-014 Prescaler: down-counter; tick = enable && presc==0; on a tick it reloads pwm_div, otherwise it decrements while enable is high; tick period = pwm_div+1 cycles.
REQ-015 PWM counter pwm_cnt, PWM_BITS wide: advances only on tick; counts 0..MAX-1, then wraps to 0; frame = MAX ticks; frame_end = tick && pwm_cnt==MAX-1.
REQ-016 Each LED i has a brightness register level[i], PWM_BITS wide; level MAX = on for the full frame, level 0 = off.
REQ-017 led[i] is registered as (level[i] > pwm_cnt), giving one cycle of latency from the register values; duty = level[i]/MAX.
REQ-018 Step counter: increments on frame_end; on a frame_end with step counter == step_div, it clears and a step occurs in the same edge.
REQ-019 On a step, every level[i] is replaced by level[i]>>1 (trail decay), then level[new pos] is set to MAX; set overrides decay.
REQ-020 Bounce mode: next pos = pos+1 if dir=1, else pos-1; on reaching N_LEDS-1 or 0, dir inverts in the same step (sequence 0,1,..,N-1,N-2,..,0,1,..); head stays at each end for exactly one step.
REQ-021 Wrap mode: dir forced to 1 on the next step; next pos = pos+1, with N_LEDS-1 wrapping to 0.
REQ-022 Mode changes take effect only at the next step; if pos is at an end when bounce resumes, the direction is corrected on that step.
REQ-023 N_LEDS=1: pos stays 0, dir stays 1, level[0] stays MAX, and step_pulse still fires.
REQ-024 enable low: prescaler, pwm_cnt, step counter, levels, pos, dir and led hold; step_pulse = 0; resuming continues cycle-exact from the frozen state.
REQ-025 pwm_div and step_div are sampled live at each reload and compare; changing them mid-count produces no glitch beyond one irregular period.

Reset
REQ-026 When reset_n=0 at a clock edge: led=0, pos=0, dir=1, step_pulse=0, presc=0, pwm_cnt=0, step counter=0, level[0]=MAX, all other levels 0.
REQ-027 Reset overrides enable and any in-progress frame or step; the first tick occurs in the first enabled cycle after release.

Verification
REQ-028 Bench configuration N_LEDS=4, PWM_BITS=3 (MAX=7), pwm_div=0, step_div=0, mode=0, unless noted; run each scenario below.
- Reset: reset_n low 3 cycles mid-scan -> all REQ-026 values; after release led=0001 for the whole first 7-cycle frame.
- Bounce: free-run 8 steps -> pos 0,1,2,3,2,1,0,1; dir 1,1,1,0,0,0,1,1; step_pulse once every 7 cycles.
- Trail: after steps to pos 1 and then pos 2 -> level[0] goes 7,3,1,0 over successive steps; led[0] high 3 of 7 cycles, then 1 of 7, then 0.
- Wrap: mode=1 from pos 2 with dir=0 -> pos 3,0,1,2, dir=1 throughout.
- Freeze: enable low 20 cycles mid-frame -> led, pos and pwm_cnt unchanged; post-resume trace equals the unfrozen trace shifted by 20 cycles.
- Prescale: pwm_div=4, step_div=2 -> tick every 5 cycles; step every 105 cycles.

Source files
------------

// File: rtl/knight_scan_pwm_if.sv
// -----------------------------------------------------------------------------
// knight_scan_pwm_if
// Control and LED-drive bundle for the knight_scan_pwm scanner.
//
// Signals:
//   enable     - high runs the scanner; low freezes all state
//   mode       - 0 = bounce scan, 1 = wrap scan
//   pwm_div    - PWM tick period minus one, in clock cycles
//   step_div   - PWM frames per scan step minus one
//   led        - PWM-modulated LED drive (registered)
//   pos        - current head position
//   dir        - scan direction, 1 = increasing index
//   step_pulse - one-cycle strobe in the first cycle pos shows a new value
//
// Modports:
//   master - the controller side (drives configuration, observes outputs)
//   slave  - the scanner side (knight_scan_pwm)
// -----------------------------------------------------------------------------
interface knight_scan_pwm_if #(
    parameter int unsigned N_LEDS  = 8,
    parameter int unsigned PRESC_W = 16
);
    localparam int unsigned POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

    logic               enable;
    logic               mode;
    logic [PRESC_W-1:0] pwm_div;
    logic [7:0]         step_div;
    logic [N_LEDS-1:0]  led;
    logic [POS_W-1:0]   pos;
    logic               dir;
    logic               step_pulse;

    modport master (
        output enable,
        output mode,
        output pwm_div,
        output step_div,
        input  led,
        input  pos,
        input  dir,
        input  step_pulse
    );

    modport slave (
        input  enable,
        input  mode,
        input  pwm_div,
        input  step_div,
        output led,
        output pos,
        output dir,
        output step_pulse
    );
endinterface

// File: rtl/knight_scan_pwm.sv
// -----------------------------------------------------------------------------
// knight_scan_pwm
// "Knight rider" LED scanner: a bright head sweeps across N_LEDS outputs and
// leaves a decaying trail. Each LED is driven by a PWM comparator against a
// shared frame counter; the head advances once every (step_div+1) PWM frames.
//
// Ports:
//   clk_in  - single clock, all state changes on its rising edge
//   reset_n - synchronous active-low reset
//   bus     - knight_scan_pwm_if.slave: enable, mode, pwm_div, step_div in;
//             led, pos, dir, step_pulse out
//
// Timing chain:
//   prescaler (pwm_div+1 cycles) -> tick -> pwm_cnt (0..MAX-1)
//   -> frame_end -> step counter (0..step_div) -> step
// -----------------------------------------------------------------------------
module knight_scan_pwm #(
    parameter int unsigned N_LEDS   = 8,
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned PRESC_W  = 16
) (
    input logic              clk_in,
    input logic              reset_n,
    knight_scan_pwm_if.slave bus
);
    localparam int unsigned POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LAST_CNT = MAX - 1'b1;
    localparam logic [POS_W-1:0]    POS_LAST = POS_W'(N_LEDS - 1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [7:0]          step_cnt_q, step_cnt_d;
    logic [PWM_BITS-1:0] level_q [N_LEDS];
    logic [PWM_BITS-1:0] level_d [N_LEDS];
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                dir_q, dir_d;
    logic [N_LEDS-1:0]   led_q, led_d;
    logic                step_pulse_q, step_pulse_d;

    // ---------------------------------------------------------------------
    // Timing strobes
    // ---------------------------------------------------------------------
    logic tick;
    logic frame_end;
    logic step;

    assign tick      = bus.enable && (presc_q == '0);
    assign frame_end = tick && (pwm_cnt_q == LAST_CNT);
    // step_div is compared live; a value below the running count just lets the
    // counter run on and wrap once, giving a single long period.
    assign step      = frame_end && (step_cnt_q == bus.step_div);

    // ---------------------------------------------------------------------
    // Prescaler, PWM frame counter, step counter
    // ---------------------------------------------------------------------
    always_comb begin
        presc_d    = presc_q;
        pwm_cnt_d  = pwm_cnt_q;
        step_cnt_d = step_cnt_q;

        if (bus.enable) begin
            // pwm_div is sampled only at reload, so a change lands cleanly.
            presc_d = tick ? bus.pwm_div : presc_q - 1'b1;
        end

        if (tick) begin
            pwm_cnt_d = frame_end ? '0 : pwm_cnt_q + 1'b1;
        end

        if (frame_end) begin
            step_cnt_d = step ? '0 : step_cnt_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Head movement
    // ---------------------------------------------------------------------
    logic [POS_W-1:0] pos_nxt;
    logic             dir_nxt;
    logic             eff_dir;

    always_comb begin
        pos_nxt = pos_q;
        dir_nxt = dir_q;
        eff_dir = dir_q;

        if (N_LEDS == 1) begin
            pos_nxt = '0;
            dir_nxt = 1'b1;
        end else if (bus.mode) begin
            pos_nxt = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
            dir_nxt = 1'b1;
        end else begin
            // Sitting at an end (e.g. after wrap mode) forces the way out,
            // whatever dir currently says.
            if (pos_q == POS_LAST) begin
                eff_dir = 1'b0;
            end else if (pos_q == '0) begin
                eff_dir = 1'b1;
            end

            pos_nxt = eff_dir ? pos_q + 1'b1 : pos_q - 1'b1;

            // Turn around in the same step that reaches an end, so the head
            // spends exactly one step there.
            if (pos_nxt == POS_LAST) begin
                dir_nxt = 1'b0;
            end else if (pos_nxt == '0) begin
                dir_nxt = 1'b1;
            end else begin
                dir_nxt = eff_dir;
            end
        end
    end

    always_comb begin
        pos_d        = pos_q;
        dir_d        = dir_q;
        step_pulse_d = step;

        if (step) begin
            pos_d = pos_nxt;
            dir_d = dir_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Brightness trail and PWM comparators
    // ---------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            level_d[i] = level_q[i];
            if (step) begin
                // Halve every level, then relight the new head at full scale.
                level_d[i] = level_q[i] >> 1;
                if (pos_nxt == POS_W'(i)) begin
                    level_d[i] = MAX;
                end
            end
        end
    end

    always_comb begin
        led_d = led_q;
        if (bus.enable) begin
            for (int unsigned i = 0; i < N_LEDS; i++) begin
                led_d[i] = (level_q[i] > pwm_cnt_q);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            presc_q      <= '0;
            pwm_cnt_q    <= '0;
            step_cnt_q   <= '0;
            pos_q        <= '0;
            dir_q        <= 1'b1;
            led_q        <= '0;
            step_pulse_q <= 1'b0;
            for (int unsigned i = 0; i < N_LEDS; i++) begin
                level_q[i] <= (i == 0) ? MAX : '0;
            end
        end else begin
            presc_q      <= presc_d;
            pwm_cnt_q    <= pwm_cnt_d;
            step_cnt_q   <= step_cnt_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            led_q        <= led_d;
            step_pulse_q <= step_pulse_d;
            for (int unsigned i = 0; i < N_LEDS; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.led        = led_q;
    assign bus.pos        = pos_q;
    assign bus.dir        = dir_q;
    assign bus.step_pulse = step_pulse_q;

endmodule
